// File: rtl/coin_change_dispenser.sv
// Change/refund dispenser: drives the 1- and 2-rupee hopper solenoids, confirms coins via the chute sensor.
// Optional macro DISP_HOPPER2_EMPTY_EN adds i_hopper2_empty to force 1-rupee coins when the 2-rupee hopper is dry.
module coin_change_dispenser #(
    parameter int AMT_W          = 4,
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
`ifdef DISP_HOPPER2_EMPTY_EN
    input  logic             i_hopper2_empty,
`endif
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req_valid,
    input  logic [AMT_W-1:0] i_req_amount,
    output logic             o_req_ready,
    output logic             o_eject_1,
    output logic             o_eject_2,
    input  logic             i_coin_seen,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fault,
    output logic [AMT_W-1:0] o_remaining
);

    localparam int CNT_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT,
        DONE,
        FAULT
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_coin2;
    logic             r_eject_1;
    logic             r_eject_2;
    logic             r_busy;
    logic             r_done;
    logic             r_fault;
    logic             r_ready;
    logic [AMT_W-1:0] r_remaining;

    logic             w_h2empty;
    logic [AMT_W-1:0] w_nextRem;
    logic             w_take2Req;
    logic             w_take2Next;

`ifdef DISP_HOPPER2_EMPTY_EN
    assign w_h2empty = i_hopper2_empty;
`else
    assign w_h2empty = 1'b0;
`endif

    // A 2-rupee coin is only chosen when at least 2 is owed, so the balance never underflows.
    assign w_nextRem   = r_remaining - (r_coin2 ? AMT_W'(2) : AMT_W'(1));
    assign w_take2Req  = (i_req_amount >= AMT_W'(2)) && !w_h2empty;
    assign w_take2Next = (w_nextRem >= AMT_W'(2)) && !w_h2empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_coin2     <= 1'b0;
            r_eject_1   <= 1'b0;
            r_eject_2   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_ready     <= 1'b1;
            r_remaining <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, FAULT: begin
                    if (i_req_valid) begin
                        r_remaining <= i_req_amount;
                        r_fault     <= 1'b0;
                        r_cnt       <= '0;
                        r_ready     <= 1'b0;
                        if (i_req_amount == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= PULSE;
                            r_busy    <= 1'b1;
                            r_coin2   <= w_take2Req;
                            r_eject_2 <= w_take2Req;
                            r_eject_1 <= !w_take2Req;
                        end
                    end
                end
                PULSE: begin
                    if (r_cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                        r_state   <= WAIT;
                        r_cnt     <= '0;
                        r_eject_1 <= 1'b0;
                        r_eject_2 <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (i_coin_seen) begin
                        r_remaining <= w_nextRem;
                        r_cnt       <= '0;
                        if (w_nextRem == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= PULSE;
                            r_coin2   <= w_take2Next;
                            r_eject_2 <= w_take2Next;
                            r_eject_1 <= !w_take2Next;
                        end
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= FAULT;
                        r_fault <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready = r_ready;
    assign o_eject_1   = r_eject_1;
    assign o_eject_2   = r_eject_2;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_fault     = r_fault;
    assign o_remaining = r_remaining;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser with hand-computed expectations.
module tb_coin_change_dispenser;

    logic       clk;
    logic       rst;
    logic       reqValid;
    logic [3:0] reqAmount;
    logic       reqReady;
    logic       eject1;
    logic       eject2;
    logic       coinSeen;
    logic       busy;
    logic       done;
    logic       fault;
    logic [3:0] remaining;
`ifdef DISP_HOPPER2_EMPTY_EN
    logic       hopper2Empty;
`endif

    int nChecks = 0;
    int nBad    = 0;

    coin_change_dispenser #(.AMT_W(4), .PULSE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
`ifdef DISP_HOPPER2_EMPTY_EN
        .i_hopper2_empty(hopper2Empty),
`endif
        .clk(clk),
        .rst(rst),
        .i_req_valid(reqValid),
        .i_req_amount(reqAmount),
        .o_req_ready(reqReady),
        .o_eject_1(eject1),
        .o_eject_2(eject2),
        .i_coin_seen(coinSeen),
        .o_busy(busy),
        .o_done(done),
        .o_fault(fault),
        .o_remaining(remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Presents a request for exactly one edge.
    task automatic applyStimulus(input logic [3:0] amount);
        reqValid  = 1'b1;
        reqAmount = amount;
        tick();
        reqValid  = 1'b0;
    endtask

    // Checks a full solenoid pulse, then confirms the coin on the second WAIT cycle.
    task automatic doCoin(input logic is2, input logic [3:0] expRem);
        for (int i = 0; i < 4; i++) begin
            checkOutput("eject2", eject2, is2);
            checkOutput("eject1", eject1, !is2);
            checkOutput("busyPulse", busy, 1);
            tick();
        end
        checkOutput("ejectOffWait", {eject2, eject1}, 0);
        checkOutput("busyWait", busy, 1);
        tick();
        coinSeen = 1'b1;
        tick();
        coinSeen = 1'b0;
        checkOutput("remaining", remaining, expRem);
    endtask

    initial begin
        rst       = 1'b1;
        reqValid  = 1'b0;
        reqAmount = '0;
        coinSeen  = 1'b0;
`ifdef DISP_HOPPER2_EMPTY_EN
        hopper2Empty = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rstReady", reqReady, 1);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstFault", fault, 0);
        checkOutput("rstRem", remaining, 0);
        checkOutput("rstEject", {eject2, eject1}, 0);

        // 5 rupees: 2 + 2 + 1
        applyStimulus(4'd5);
        checkOutput("acceptRem", remaining, 5);
        checkOutput("acceptReady", reqReady, 0);
        doCoin(1'b1, 4'd3);
        checkOutput("doneEarly", done, 0);
        doCoin(1'b1, 4'd1);
        doCoin(1'b0, 4'd0);
        checkOutput("donePulse", done, 1);
        checkOutput("doneBusy", busy, 0);
        checkOutput("doneFault", fault, 0);
        tick();
        checkOutput("doneOnce", done, 0);
        checkOutput("idleReady", reqReady, 1);

        // zero amount
        applyStimulus(4'd0);
        checkOutput("zeroDone", done, 1);
        checkOutput("zeroEject", {eject2, eject1}, 0);
        checkOutput("zeroBusy", busy, 0);
        tick();
        checkOutput("zeroDoneOnce", done, 0);
        checkOutput("zeroReady", reqReady, 1);

        // timeout then recovery
        applyStimulus(4'd3);
        for (int i = 0; i < 4; i++) begin
            checkOutput("toEject2", eject2, 1);
            tick();
        end
        for (int i = 0; i < 15; i++) tick();
        checkOutput("toNotYet", fault, 0);
        checkOutput("toBusyYet", busy, 1);
        tick();
        checkOutput("toFault", fault, 1);
        checkOutput("toRem", remaining, 3);
        checkOutput("toReady", reqReady, 1);
        checkOutput("toBusy", busy, 0);
        checkOutput("toDone", done, 0);
        coinSeen = 1'b1;
        tick();
        coinSeen = 1'b0;
        checkOutput("faultIgnoresCoin", remaining, 3);
        applyStimulus(4'd1);
        checkOutput("faultCleared", fault, 0);
        checkOutput("recoverRem", remaining, 1);
        doCoin(1'b0, 4'd0);
        checkOutput("recoverDone", done, 1);
        tick();

        // reset mid-pulse
        applyStimulus(4'd2);
        tick();
        checkOutput("midPulseEject2", eject2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstMidEject", {eject2, eject1}, 0);
        checkOutput("rstMidBusy", busy, 0);
        checkOutput("rstMidRem", remaining, 0);
        checkOutput("rstMidReady", reqReady, 1);
        coinSeen = 1'b1;
        tick();
        coinSeen = 1'b0;
        checkOutput("rstCoinRem", remaining, 0);
        checkOutput("rstCoinDone", done, 0);

        // requests while busy are ignored
        reqValid  = 1'b1;
        reqAmount = 4'd4;
        tick();
        reqAmount = 4'd7;
        checkOutput("busyAcceptRem", remaining, 4);
        doCoin(1'b1, 4'd2);
        reqValid = 1'b0;
        checkOutput("busyReady", reqReady, 0);
        doCoin(1'b1, 4'd0);
        checkOutput("busyDone", done, 1);
        tick();
        coinSeen = 1'b1;
        tick();
        coinSeen = 1'b0;
        checkOutput("idleCoinRem", remaining, 0);
        checkOutput("idleCoinBusy", busy, 0);
        checkOutput("idleCoinReady", reqReady, 1);
        checkOutput("idleCoinEject", {eject2, eject1}, 0);

`ifdef DISP_HOPPER2_EMPTY_EN
        hopper2Empty = 1'b1;
        applyStimulus(4'd2);
        doCoin(1'b0, 4'd1);
        doCoin(1'b0, 4'd0);
        checkOutput("h2Done", done, 1);
        tick();
        hopper2Empty = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule

// File: doc/coin_change_dispenser.md
Name: coin_change_dispenser

Overview:
Return-path counterpart to the coin-accepting vending FSM. The vending controller accepts coin codes and releases product; this block takes a change or refund amount in rupees and drives the 1- and 2-rupee hopper eject solenoids. It confirms each coin through the chute sensor, tracks the remaining balance, and flags a jam on timeout. It sits between the vending controller (request side) and the hopper hardware (solenoid and sensor side).

Parameters:
AMT_W, 4, width of the request amount and remaining balance in rupees
PULSE_CYCLES, 4, solenoid pulse width in clk cycles (>=1)
TIMEOUT_CYCLES, 16, maximum WAIT cycles for chute confirmation before fault (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
req_valid  in  1  change request present
req_amount  in  AMT_W  rupees to return
req_ready  out  1  block can accept a request
eject_1  out  1  1-rupee hopper solenoid drive
eject_2  out  1  2-rupee hopper solenoid drive
coin_seen  in  1  chute sensor, high for >=1 cycle per coin dropped
busy  out  1  dispense in progress
done  out  1  one-cycle pulse when the full amount has been returned
fault  out  1  jam/timeout flag
remaining  out  AMT_W  rupees still owed

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; eject_1=0, eject_2=0, done=0, fault=0, busy=0, remaining=0, req_ready=1. Reset overrides everything, including mid-pulse.
- States: IDLE, PULSE, WAIT, DONE, FAULT.
- req_ready=1 in IDLE and FAULT only. A request is accepted at an edge where req_valid && req_ready. req_valid in any other state is ignored; no queueing.
- On acceptance of amount A at edge T:
  - remaining <= A; fault <= 0.
  - If A==0: go to DONE (done=1 for cycle T+1, then IDLE).
  - Otherwise go to PULSE.
- Coin choice, greedy, made on entering PULSE: remaining>=2 -> eject_2, otherwise eject_1. Exactly one eject line is high, and only in PULSE.
- PULSE: the selected eject line is high for exactly PULSE_CYCLES cycles, then WAIT. coin_seen is ignored during PULSE.
- WAIT:
  - Cycle counter runs from 0.
  - coin_seen=1 in a WAIT cycle: remaining decrements by the value of the coin just ejected at the next edge.
  - If the new remaining is 0, go to DONE. Otherwise go to PULSE for the next coin (no gap cycle).
- Timeout: TIMEOUT_CYCLES consecutive WAIT cycles without coin_seen -> FAULT. In FAULT: fault=1, busy=0, remaining holds the unreturned amount, no done pulse.
- FAULT exit: FAULT persists until rst or a new accepted request, which clears fault at the acceptance edge.
- DONE lasts one cycle: done=1, busy=0, then IDLE.
- busy=1 in PULSE and WAIT only.
- coin_seen is ignored in IDLE, DONE and FAULT. A coin_seen held high across several WAIT cycles counts once, because the state leaves WAIT on the first cycle.
- Arithmetic: remaining never underflows. A 2-rupee eject is only selected when remaining>=2.
- All outputs are registered or decoded directly from state; no combinational path from inputs to outputs.

Optional Feature:
DISP_HOPPER2_EMPTY_EN
- Defined: adds input port hopper2_empty (1 bit), sampled when coin choice is made on entering PULSE. If it is 1, the 1-rupee coin is chosen even when remaining>=2, so 2-rupee amounts are paid in 1-rupee coins.
- Undefined: the port is absent and selection is pure greedy as above.

Test Plan:
1. req_amount=5 accepted after reset; coin_seen pulsed 2 cycles into each WAIT -> eject_2 4 cycles, eject_2 4 cycles, eject_1 4 cycles; remaining steps 5->3->1->0; single done pulse; fault=0.
2. req_amount=0 -> done=1 the cycle after acceptance; no eject activity; back to req_ready=1.
3. req_amount=3, coin_seen never asserted -> eject_2 4 cycles, then after 16 WAIT cycles fault=1, remaining=3, req_ready=1; then req_amount=1 with coin_seen -> fault clears at acceptance, eject_1 pulse, done pulse.
4. rst asserted on the 2nd cycle of an eject_2 pulse -> at the next edge eject_2=0, busy=0, remaining=0, req_ready=1; coin_seen afterwards ignored.
5. req_valid held high with new amounts during PULSE/WAIT, and coin_seen pulsed in IDLE -> neither accepted; remaining and state unaffected.
6. (DISP_HOPPER2_EMPTY_EN) hopper2_empty=1, req_amount=2 -> two eject_1 pulses, no eject_2, done pulse.
